// File: rtl/rvfi_liveness_pkg.sv
// Shared types and helpers for the RVFI forward-progress checker.
package rvfi_liveness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LIVE   = 2'd1,
    ST_HALTED = 2'd2,
    ST_WFI    = 2'd3
  } state_e;

  localparam logic [31:0] WFI_INSN = 32'h1050_0073;
  localparam int          MAX_NRET = 32;

  // Counts the set bits among the lowest nret bits of v.
  function automatic int popcount(input logic [MAX_NRET-1:0] v, input int nret);
    int n;
    n = 0;
    for (int i = 0; i < MAX_NRET; i++) begin
      if (i < nret && v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/rvfi_sat_counter.sv
// Saturating accumulator with hold (freeze) and synchronous clear.
module rvfi_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             freeze_i,
  input  logic [WIDTH-1:0] add_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  // Freeze wins over clear so a halted or sleeping core cannot disturb the count.
  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, add_i};
    cnt_d = cnt_q;
    if (freeze_i)     cnt_d = cnt_q;
    else if (clear_i) cnt_d = '0;
    else if (sum[WIDTH]) cnt_d = '1;
    else              cnt_d = sum[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rvfi_liveness_check.sv
// Forward-progress checker on the RVFI retirement bus.
// Optional WFI tracking is enabled by defining RISCV_FORMAL_LIVENESS_WFI_EN.
//
// state  | meaning
// IDLE   | awaiting first retirement since reset
// LIVE   | retiring, MAX_STALL window enforced
// HALTED | halt retired, counters frozen until reset
// WFI    | sleeping after a WFI, stall timer held
module rvfi_liveness_check
  import rvfi_liveness_pkg::*;
#(
  parameter int NRET       = 1,
  parameter int ILEN       = 32,
  parameter int CNT_W      = 8,
  parameter int FIRST_MAX  = 32,
  parameter int MAX_STALL  = 16,
  parameter int MIN_RETIRE = 1,
  parameter int ALLOW_HALT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 trig,
  input  logic                 check,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET-1:0]      rvfi_halt,
  input  logic [NRET*ILEN-1:0] rvfi_insn,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     retire_cnt_o,
  output logic                 fail_o
);

  if (MAX_STALL >= (1 << CNT_W) || FIRST_MAX >= (1 << CNT_W) ||
      MIN_RETIRE > (1 << CNT_W) - 1) begin : g_bad_params
    $error("rvfi_liveness_check: limits do not fit in CNT_W bits");
  end

  state_e                state_q;
  logic                  fail_q;
  logic                  any_valid, halt_ret, wfi_seen, wfi_ret;
  logic                  stall_hit, check_hit, stall_freeze, retire_freeze;
  logic [MAX_NRET-1:0]   valid_ext;
  logic [CNT_W-1:0]      nret_add;
  logic [CNT_W:0]        stall_nxt;
  logic                  unused_ok;

  assign valid_ext = MAX_NRET'(rvfi_valid);
  assign nret_add  = CNT_W'(popcount(valid_ext, NRET));
  assign any_valid = |rvfi_valid;
  assign halt_ret  = (ALLOW_HALT != 0) && (|(rvfi_valid & rvfi_halt));

  always_comb begin
    wfi_seen = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      if (rvfi_valid[c] && rvfi_insn[c*ILEN +: ILEN] == ILEN'(WFI_INSN)) wfi_seen = 1'b1;
    end
  end

`ifdef RISCV_FORMAL_LIVENESS_WFI_EN
  assign wfi_ret = wfi_seen;
`else
  assign wfi_ret = 1'b0;
`endif

  assign unused_ok = ^{trig, rvfi_halt, wfi_seen};

  assign retire_freeze = (state_q == ST_HALTED);
  assign stall_freeze  = retire_freeze || (state_q == ST_WFI && !any_valid);

  rvfi_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (any_valid),
    .freeze_i (stall_freeze),
    .add_i    (CNT_W'(1)),
    .cnt_o    (stall_cnt_o)
  );

  rvfi_sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (1'b0),
    .freeze_i (retire_freeze),
    .add_i    (nret_add),
    .cnt_o    (retire_cnt_o)
  );

  // The stall limit trips on the same edge the stall counter reaches it.
  assign stall_nxt = {1'b0, stall_cnt_o} + (CNT_W+1)'(1);
  assign stall_hit = !any_valid &&
                     ((state_q == ST_IDLE && stall_nxt >= (CNT_W+1)'(FIRST_MAX)) ||
                      (state_q == ST_LIVE && stall_nxt >= (CNT_W+1)'(MAX_STALL)));
  assign check_hit = check && ({1'b0, retire_cnt_o} < (CNT_W+1)'(MIN_RETIRE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fail_q  <= 1'b0;
    end else begin
      if (stall_hit || check_hit) fail_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (any_valid) state_q <= halt_ret ? ST_HALTED : ST_LIVE;
        ST_LIVE: begin
          if (halt_ret)     state_q <= ST_HALTED;
          else if (wfi_ret) state_q <= ST_WFI;
        end
        ST_WFI:  if (any_valid) state_q <= halt_ret ? ST_HALTED : ST_LIVE;
        default: state_q <= state_q;
      endcase
    end
  end

  assign state_o = state_q;
  assign fail_o  = fail_q;

`ifdef FORMAL
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!fail_o);
      if (check) assert (retire_cnt_o >= CNT_W'(MIN_RETIRE));
      if (ALLOW_HALT == 0) assume (!(|(rvfi_valid & rvfi_halt)));
`ifndef RISCV_FORMAL_LIVENESS_WFI_EN
      assume (!wfi_seen);
      assert (state_q != ST_WFI);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_liveness_check.sv
// Directed bench for rvfi_liveness_check: a vector table on a single-channel
// instance plus hand sequences for multi-channel, halt, saturation and WFI.
module tb_rvfi_liveness_check;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WFI = 32'h1050_0073;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        trig  = 1'b0;
  logic        check = 1'b0;
  logic [1:0]  valid = 2'b00;
  logic [1:0]  halt  = 2'b00;
  logic [63:0] insn  = {NOP, NOP};

  logic [1:0] st_a, st_b, st_c;
  logic [7:0] stall_a, ret_a, stall_b, ret_b;
  logic [3:0] stall_c, ret_c;
  logic       fail_a, fail_b, fail_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  rvfi_liveness_check #(.NRET(1), .CNT_W(8), .FIRST_MAX(6), .MAX_STALL(4),
                        .MIN_RETIRE(1), .ALLOW_HALT(0)) dut_a (
    .clock(clock), .reset(reset), .trig(trig), .check(check),
    .rvfi_valid(valid[0:0]), .rvfi_halt(halt[0:0]), .rvfi_insn(insn[31:0]),
    .state_o(st_a), .stall_cnt_o(stall_a), .retire_cnt_o(ret_a), .fail_o(fail_a));

  rvfi_liveness_check #(.NRET(2), .CNT_W(8), .FIRST_MAX(32), .MAX_STALL(16),
                        .MIN_RETIRE(6), .ALLOW_HALT(1)) dut_b (
    .clock(clock), .reset(reset), .trig(trig), .check(check),
    .rvfi_valid(valid), .rvfi_halt(halt), .rvfi_insn(insn),
    .state_o(st_b), .stall_cnt_o(stall_b), .retire_cnt_o(ret_b), .fail_o(fail_b));

  rvfi_liveness_check #(.NRET(1), .CNT_W(4), .FIRST_MAX(8), .MAX_STALL(4),
                        .MIN_RETIRE(0), .ALLOW_HALT(0)) dut_c (
    .clock(clock), .reset(reset), .trig(trig), .check(check),
    .rvfi_valid(valid[0:0]), .rvfi_halt(halt[0:0]), .rvfi_insn(insn[31:0]),
    .state_o(st_c), .stall_cnt_o(stall_c), .retire_cnt_o(ret_c), .fail_o(fail_c));

  typedef struct {
    logic        rst;
    logic        v;
    logic        h;
    logic        c;
    logic [31:0] st;
    logic [31:0] stall;
    logic [31:0] ret;
    logic [31:0] fail;
  } vec_t;

  vec_t vq[$];

  task automatic add_v(input logic rst, input logic v, input logic h, input logic c,
                       input int st, input int stall, input int ret, input int f);
    vec_t e;
    e.rst = rst; e.v = v; e.h = h; e.c = c;
    e.st = 32'(st); e.stall = 32'(stall); e.ret = 32'(ret); e.fail = 32'(f);
    vq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and land 1ns after the rising edge.
  task automatic step(input logic r, input logic [1:0] v, input logic [1:0] h,
                      input logic c, input logic [31:0] i0);
    reset = r; valid = v; halt = h; check = c; insn = {NOP, i0};
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Retire every third cycle under MAX_STALL=4, then starve it.
    add_v(1,0,0,0, 0,0,0,0);
    add_v(0,0,0,0, 0,1,0,0);
    add_v(0,0,0,0, 0,2,0,0);
    add_v(0,1,0,0, 1,0,1,0);
    add_v(0,0,0,0, 1,1,1,0);
    add_v(0,0,0,0, 1,2,1,0);
    add_v(0,1,0,0, 1,0,2,0);
    add_v(0,0,0,0, 1,1,2,0);
    add_v(0,0,0,0, 1,2,2,0);
    add_v(0,1,0,0, 1,0,3,0);
    add_v(0,0,0,0, 1,1,3,0);
    add_v(0,0,0,0, 1,2,3,0);
    add_v(0,0,0,0, 1,3,3,0);
    add_v(0,0,0,0, 1,4,3,1);
    add_v(0,0,0,0, 1,5,3,1);
    // FIRST_MAX=6 with a reset at cycle 3, then the full window.
    add_v(1,0,0,0, 0,0,0,0);
    add_v(0,0,0,0, 0,1,0,0);
    add_v(0,0,0,0, 0,2,0,0);
    add_v(0,0,0,0, 0,3,0,0);
    add_v(1,0,0,0, 0,0,0,0);
    add_v(0,0,0,0, 0,1,0,0);
    add_v(0,0,0,0, 0,2,0,0);
    add_v(0,0,0,0, 0,3,0,0);
    add_v(0,0,0,0, 0,4,0,0);
    add_v(0,0,0,0, 0,5,0,0);
    add_v(0,0,0,0, 0,6,0,1);
    add_v(0,0,0,0, 0,7,0,1);
    // MIN_RETIRE=1: empty check, same-cycle retire, then a good check.
    add_v(1,0,0,0, 0,0,0,0);
    add_v(0,0,0,1, 0,1,0,1);
    add_v(1,0,0,0, 0,0,0,0);
    add_v(0,1,0,1, 1,0,1,1);
    add_v(1,0,0,0, 0,0,0,0);
    add_v(0,1,0,0, 1,0,1,0);
    add_v(0,0,0,1, 1,1,1,0);
    // Halt ignored when ALLOW_HALT=0: stays LIVE and starves.
    add_v(1,0,0,0, 0,0,0,0);
    add_v(0,0,0,0, 0,1,0,0);
    add_v(0,0,0,0, 0,2,0,0);
    add_v(0,1,1,0, 1,0,1,0);
    add_v(0,0,0,0, 1,1,1,0);
    add_v(0,0,0,0, 1,2,1,0);
    add_v(0,0,0,0, 1,3,1,0);
    add_v(0,0,0,0, 1,4,1,1);

    foreach (vq[k]) begin
      step(vq[k].rst, {1'b0, vq[k].v}, {1'b0, vq[k].h}, vq[k].c, NOP);
      chk($sformatf("vec%0d.state", k), 32'(st_a),    vq[k].st);
      chk($sformatf("vec%0d.stall", k), 32'(stall_a), vq[k].stall);
      chk($sformatf("vec%0d.ret", k),   32'(ret_a),   vq[k].ret);
      chk($sformatf("vec%0d.fail", k),  32'(fail_a),  vq[k].fail);
    end

    // Dual channel, MIN_RETIRE=6: three double retires then a check.
    step(1, 2'b00, 2'b00, 0, NOP);
    chk("b_reset_state", 32'(st_b), 32'd0);
    chk("b_reset_ret",   32'(ret_b), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 2'b11, 2'b00, 0, NOP);
      chk($sformatf("b_dual_ret%0d", i), 32'(ret_b), 32'(2 * i));
      chk($sformatf("b_dual_stall%0d", i), 32'(stall_b), 32'd0);
    end
    chk("b_dual_state", 32'(st_b), 32'd1);
    step(0, 2'b00, 2'b00, 1, NOP);
    chk("b_check_ret", 32'(ret_b), 32'd6);
    chk("b_check_fail", 32'(fail_b), 32'd0);

    // Check coincident with the third retire sees only 4.
    step(1, 2'b00, 2'b00, 0, NOP);
    step(0, 2'b11, 2'b00, 0, NOP);
    step(0, 2'b11, 2'b00, 0, NOP);
    step(0, 2'b11, 2'b00, 1, NOP);
    chk("b_samecyc_ret", 32'(ret_b), 32'd6);
    chk("b_samecyc_fail", 32'(fail_b), 32'd1);

    // Halt at cycle 3: B halts, A (halt not allowed) stays LIVE and starves.
    step(1, 2'b00, 2'b00, 0, NOP);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 0, NOP);
    chk("b_pre_halt_stall", 32'(stall_b), 32'd3);
    step(0, 2'b01, 2'b01, 0, NOP);
    chk("b_halt_state", 32'(st_b), 32'd2);
    chk("a_halt_ignored", 32'(st_a), 32'd1);
    for (int i = 0; i < 100; i++) step(0, 2'b00, 2'b00, 0, NOP);
    chk("b_halted_state", 32'(st_b), 32'd2);
    chk("b_halted_stall", 32'(stall_b), 32'd0);
    chk("b_halted_ret", 32'(ret_b), 32'd1);
    chk("b_halted_fail", 32'(fail_b), 32'd0);
    chk("a_nohalt_fail", 32'(fail_a), 32'd1);
    step(0, 2'b11, 2'b00, 0, NOP);
    chk("b_halted_frozen_ret", 32'(ret_b), 32'd1);
    chk("b_halted_frozen_st", 32'(st_b), 32'd2);

    // Halt on one channel of a double retire straight from IDLE.
    step(1, 2'b00, 2'b00, 0, NOP);
    step(0, 2'b11, 2'b10, 0, NOP);
    chk("b_multi_halt_state", 32'(st_b), 32'd2);
    chk("b_multi_halt_ret", 32'(ret_b), 32'd2);

    // CNT_W=4: retire counter saturates at 15.
    step(1, 2'b00, 2'b00, 0, NOP);
    for (int i = 1; i <= 20; i++) begin
      step(0, 2'b01, 2'b00, 1, NOP);
      chk($sformatf("c_sat_ret%0d", i), 32'(ret_c), 32'((i > 15) ? 15 : i));
      chk($sformatf("c_sat_fail%0d", i), 32'(fail_c), 32'd0);
    end
    chk("c_sat_stall", 32'(stall_c), 32'd0);

`ifdef RISCV_FORMAL_LIVENESS_WFI_EN
    // WFI: LIVE -> WFI, 50 quiet cycles with the timer held, then LIVE.
    step(1, 2'b00, 2'b00, 0, NOP);
    step(0, 2'b01, 2'b00, 0, NOP);
    chk("w_live", 32'(st_b), 32'd1);
    step(0, 2'b01, 2'b00, 0, WFI);
    chk("w_enter", 32'(st_b), 32'd3);
    for (int i = 0; i < 50; i++) step(0, 2'b00, 2'b00, 0, NOP);
    chk("w_hold_state", 32'(st_b), 32'd3);
    chk("w_hold_stall", 32'(stall_b), 32'd0);
    chk("w_hold_fail_b", 32'(fail_b), 32'd0);
    chk("w_hold_fail_a", 32'(fail_a), 32'd0);
    step(0, 2'b01, 2'b00, 0, NOP);
    chk("w_exit_state", 32'(st_b), 32'd1);
    chk("w_exit_stall", 32'(stall_b), 32'd0);
    chk("w_exit_ret", 32'(ret_b), 32'd3);
    step(0, 2'b00, 2'b00, 0, NOP);
    chk("w_resume_stall", 32'(stall_b), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvfi_liveness_check.md
Name: rvfi_liveness_check

Overview:
- Parametrised forward-progress checker on the RVFI retirement bus.
- Generalises the single "retired at least once before check" property in four ways:
  - bounded stall windows, before and after the first retirement;
  - a minimum retirement count at check time;
  - an optional halt mode;
  - optional WFI handling.
- Instantiated by the formal wrapper beside the core under test, driven by the same clock/reset/check/trig as other rvfi checks.
- Sticky failure flag and counters are exported as ports so sim benches can observe them.

Parameters:
- NRET, 1, retirement channels (matches RISCV_FORMAL_NRET)
- ILEN, 32, instruction width per channel
- CNT_W, 8, width of stall and retire counters
- FIRST_MAX, 32, max cycles from reset release to first retirement
- MAX_STALL, 16, max cycles between consecutive retirements once live
- MIN_RETIRE, 1, retirements required when check asserts
- ALLOW_HALT, 0, 1 = a retirement with rvfi_halt is legal and ends liveness checking

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- trig  in  1  accepted for wrapper uniformity, unused
- check  in  1  evaluate the MIN_RETIRE property this cycle
- rvfi_valid  in  NRET  per-channel retire strobe
- rvfi_halt  in  NRET  per-channel halt flag
- rvfi_insn  in  NRET*ILEN  per-channel instruction word, channel c at [(c+1)*ILEN-1 : c*ILEN]
- state_o  out  2  current FSM state encoding
- stall_cnt_o  out  CNT_W  cycles since last retirement, or since reset release
- retire_cnt_o  out  CNT_W  total retirements since reset, saturating
- fail_o  out  1  sticky liveness violation

Interface note: reset is reset, synchronous, active-high; clock is clock.

Behaviour:
- Reset (synchronous, any cycle, including mid-stall):
  - state=IDLE; stall_cnt_o=0; retire_cnt_o=0; fail_o=0.
  - Property checks are suppressed while reset is high.
- nret_this_cycle = popcount(rvfi_valid), range 0..NRET.
- Counter arithmetic:
  - retire_cnt_o += nret_this_cycle each cycle, saturating at 2^CNT_W-1.
  - stall_cnt_o increments by 1 on cycles with no retirement, saturating at 2^CNT_W-1.
  - stall_cnt_o clears to 0 on any cycle with a retirement.
- FSM states:
  - IDLE=0: awaiting first retirement.
  - LIVE=1: retiring normally.
  - HALTED=2: halt retired.
  - WFI=3: only reachable with the optional feature.
- Transitions:
  - IDLE -> LIVE on any rvfi_valid.
  - LIVE -> HALTED when any valid channel has rvfi_halt and ALLOW_HALT=1.
  - Same-cycle halt from IDLE goes straight to HALTED.
  - HALTED is terminal until reset; counters freeze; stall checks are disabled.
- Failure conditions; fail_o is set on the next clock edge and stays high until reset:
  - IDLE and stall_cnt_o reaches FIRST_MAX;
  - LIVE and stall_cnt_o reaches MAX_STALL;
  - check high and registered retire_cnt_o < MIN_RETIRE.
- Check timing: check samples the registered count. A retirement in the same cycle as check does not count for that check.
- Multi-channel: any number of simultaneous valids counts as one progress event for the stall timer. All are added to retire_cnt_o.
- Halt in the middle of a multi-retire cycle: all valid channels are still counted.
- ALLOW_HALT=0: the checker assumes !rvfi_halt[c] on every valid channel.
- Under FORMAL:
  - assert(!fail_o) each non-reset cycle;
  - assert(retire_cnt_o >= MIN_RETIRE) when check is high.
- Without FORMAL: fail_o is the only verdict.
- Elaboration error if any of the following hold:
  - MAX_STALL >= 2^CNT_W;
  - FIRST_MAX >= 2^CNT_W;
  - MIN_RETIRE > 2^CNT_W-1.

Optional Feature:
- Macro: RISCV_FORMAL_LIVENESS_WFI_EN.
- Defined:
  - A valid WFI (32'h10500073) in LIVE moves the FSM to WFI; the stall timer stops and holds its value.
  - The next retirement returns the FSM to LIVE and clears the stall timer.
  - WFI has no timeout; the bench models interrupts.
- Undefined:
  - The checker assumes rvfi_insn != WFI on every valid channel.
  - State 3 is unreachable; asserted under FORMAL.

Decomposition:
- Package rvfi_liveness_pkg:
  - state enum (IDLE/LIVE/HALTED/WFI, 2 bits);
  - WFI_INSN constant;
  - popcount function parametrised by NRET.
- One sub-module, rvfi_sat_counter (WIDTH, add input, clear, freeze; saturating). Instantiated twice, for the stall counter and the retire counter.

Test Plan:
- NRET=1, MAX_STALL=4: retire at cycles 2, 5, 8 -> fail_o stays 0, stall_cnt_o peaks at 2. Then idle 4 cycles -> fail_o=1 on the 4th idle edge.
- FIRST_MAX=6, no retirement -> state stays IDLE, fail_o=1 when stall_cnt_o reaches 6. Assert reset mid-IDLE at cycle 3 -> counters return to 0 and the fail is avoided.
- NRET=2, rvfi_valid=2'b11 for 3 cycles, then check with MIN_RETIRE=6 -> retire_cnt_o=6 and no fail. Check in the same cycle as the 3rd retire -> fail_o=1 (registered count is 4).
- ALLOW_HALT=1: halt retires at cycle 3 -> state=HALTED, no fail after 100 idle cycles. ALLOW_HALT=0 with the same stimulus -> assumption violation reported.
- With WFI_EN: WFI retires, then 50 idle cycles, then a retire -> state LIVE->WFI->LIVE, stall_cnt_o frozen then cleared, fail_o=0.
- CNT_W=4, MIN_RETIRE=0, continuous retire for 20 cycles -> retire_cnt_o saturates at 15 with no wrap.
